// File: rtl/me_wb_writeback.sv
// me_wb_writeback: two-entry writeback FIFO in front of a register file, with read forwarding.
//   clk, rst (async, active-high)
//   InValid/InReady/ResultIn/RDAddrIn : completed result coming in from EX/ME
//   WbStall                           : register-file write port blocked this cycle
//   Rs1AddrIn/Rs2AddrIn -> Rs1DataOut/Rs2DataOut : forwarded combinational reads
//   WbValidOut/WbAddrOut/WbDataOut    : registered one-cycle report of the last write
//   PendCntOut                        : results queued but not yet written
module me_wb_writeback #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [DSIZE-1:0] ResultIn,
  input  logic [ASIZE-1:0] RDAddrIn,
  input  logic             WbStall,
  input  logic [ASIZE-1:0] Rs1AddrIn,
  input  logic [ASIZE-1:0] Rs2AddrIn,
  output logic [DSIZE-1:0] Rs1DataOut,
  output logic [DSIZE-1:0] Rs2DataOut,
  output logic             WbValidOut,
  output logic [ASIZE-1:0] WbAddrOut,
  output logic [DSIZE-1:0] WbDataOut,
  output logic [1:0]       PendCntOut
);
  logic [DSIZE-1:0] dataQ   [2];
  logic [ASIZE-1:0] addrQ   [2];
  logic [DSIZE-1:0] regFile [2**ASIZE];
  logic             wrPtr, rdPtr;
  logic [1:0]       count;
  logic             push, pop;

  assign PendCntOut = count;
  assign InReady    = count < 2'd2;
  assign push       = InValid && InReady;
  assign pop        = count != 2'd0 && !WbStall;

  // The younger entry (only present when full) wins over the head, which wins over the regfile.
  function automatic logic [DSIZE-1:0] fwd(input logic [ASIZE-1:0] a);
    fwd = (count == 2'd2 && addrQ[~rdPtr] == a) ? dataQ[~rdPtr] :
          (count != 2'd0 && addrQ[rdPtr] == a)  ? dataQ[rdPtr]  : regFile[a];
  endfunction

  assign Rs1DataOut = fwd(Rs1AddrIn);
  assign Rs2DataOut = fwd(Rs2AddrIn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      WbValidOut <= 1'b0;
      WbAddrOut  <= '0;
      WbDataOut  <= '0;
      for (int i = 0; i < 2; i++) begin
        dataQ[i] <= '0;
        addrQ[i] <= '0;
      end
      for (int i = 0; i < 2**ASIZE; i++) regFile[i] <= '0;
    end else begin
      count      <= count + {1'b0, push} - {1'b0, pop};
      WbValidOut <= pop;
      if (push) begin
        dataQ[wrPtr] <= ResultIn;
        addrQ[wrPtr] <= RDAddrIn;
        wrPtr        <= ~wrPtr;
      end
      if (pop) begin
        regFile[addrQ[rdPtr]] <= dataQ[rdPtr];
        WbAddrOut             <= addrQ[rdPtr];
        WbDataOut             <= dataQ[rdPtr];
        rdPtr                 <= ~rdPtr;
      end
    end
  end
endmodule

// File: doc/me_wb_writeback.md
ME_WB_WRITEBACK -- requirements
Module: me_wb_writeback

Interface
REQ-001 Parameter DSIZE, default 32, result/register data width.
REQ-002 Parameter ASIZE, default 5, destination register address width; register file depth 2**ASIZE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 InValid  input  1  ResultIn/RDAddrIn carry a completed result from the EX/ME buffer.
REQ-006 InReady  output  1  block can accept a result this cycle.
REQ-007 ResultIn  input  DSIZE  result data.
REQ-008 RDAddrIn  input  ASIZE  destination register address.
REQ-009 WbStall  input  1  register-file write port blocked this cycle.
REQ-010 Rs1AddrIn, Rs2AddrIn  input  ASIZE each  decode-stage read addresses.
REQ-011 Rs1DataOut, Rs2DataOut  output  DSIZE each  read data with forwarding.
REQ-012 WbValidOut  output  1  one-cycle pulse: a register write completed at the previous edge.
REQ-013 WbAddrOut  output  ASIZE  address of that write.
REQ-014 WbDataOut  output  DSIZE  data of that write.
REQ-015 PendCntOut  output  2  results queued, not yet written (0..2).

Function
REQ-016 Block SHALL hold a 2-entry FIFO of {ResultIn, RDAddrIn} pairs plus a 2**ASIZE x DSIZE register file.
REQ-017 Push SHALL occur on an edge where InValid=1 and InReady=1; InValid with InReady=0 SHALL be ignored (no capture, no error).
REQ-018 InReady SHALL equal (PendCntOut < 2), derived from the current count only; no push at count 2 even if a pop occurs in the same cycle.
REQ-019 Pop SHALL occur on an edge where count > 0 and WbStall=0; pop writes head data to regfile[head address] on that edge.
REQ-020 At most one pop per cycle; FIFO order SHALL be preserved (oldest written first).
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push-only +1, pop-only -1.
REQ-022 Read/write pointers are 1 bit each and SHALL wrap 1 -> 0.
REQ-023 After each pop edge WbValidOut SHALL be 1 for exactly the following cycle, with WbAddrOut/WbDataOut equal to the written pair; otherwise WbValidOut=0 and WbAddrOut/WbDataOut hold their last values.
REQ-024 Minimum latency: result pushed at edge N into an empty FIFO with WbStall=0 SHALL be written at edge N+1; WbValidOut high in cycle N+1..N+2.
REQ-025 RsXDataOut SHALL be combinational: if any valid FIFO entry address equals RsXAddrIn, return the youngest matching entry's data; else regfile[RsXAddrIn].
REQ-026 Forwarding SHALL apply from the cycle after push until the write lands, so the reader never sees a stale value.
REQ-027 Two queued entries with the same address SHALL both be written in order; final regfile value is the younger.
REQ-028 Incoming result is not forwarded in its own push cycle (only FIFO contents and regfile).
REQ-029 Address 0 SHALL be an ordinary writable register.
REQ-030 WbStall held high SHALL freeze the FIFO head indefinitely; pushes continue until full.

Reset
REQ-031 While rst=1 (asynchronous assert): count=0, pointers=0, all FIFO entries and all regfile words = 0, WbValidOut=0, WbAddrOut=0, WbDataOut=0, PendCntOut=0, InReady=1.
REQ-032 Reset mid-operation SHALL discard queued results without writing them; no WbValidOut pulse follows.
REQ-033 First push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Single write: push {32'hAFAB0000, 30}, WbStall=0 -> next cycle WbValidOut=1, WbAddrOut=30, WbDataOut=32'hAFAB0000; then Rs1AddrIn=30 reads 32'hAFAB0000.
REQ-035 Forwarding: WbStall=1, push {32'h3F800000, 7} -> Rs2AddrIn=7 returns 32'h3F800000 while regfile[7]=0; release stall -> write at next edge.
REQ-036 Full/back-pressure: WbStall=1, push {1,3}, {2,4} -> PendCntOut=2, InReady=0; third InValid {3,5} ignored; release stall -> writes to 3 then 4 on consecutive edges, reg 5 stays 0.
REQ-037 Same-address ordering: stall, push {32'h11,9} then {32'h22,9} -> Rs1(9)=32'h22 during stall; after drain regfile[9]=32'h22, two WbValidOut pulses in order 0x11, 0x22.
REQ-038 Steady stream: push every cycle for 8 cycles, WbStall=0 -> PendCntOut stays 1, InReady stays 1, 8 WbValidOut pulses in order.
REQ-039 Reset mid-flight: stall with 2 entries queued, assert rst between edges -> outputs zero immediately, no later write, Rs1/Rs2 read 0 for those addresses.
